// File: rtl/sha_padder_if.sv
// Byte-stream input channel and padded 512-bit block output channel of the
// SHA-256 message padder.
interface sha_padder_if;
  logic         in_valid;
  logic         in_ready;
  logic [7:0]   in_data;
  logic         in_last;
  logic         in_nodata;
  logic         out_valid;
  logic         out_ready;
  logic [511:0] out_block;
  logic         out_first;
  logic         out_last;

  modport master (
    output in_valid, in_data, in_last, in_nodata, out_ready,
    input  in_ready, out_valid, out_block, out_first, out_last
  );

  modport slave (
    input  in_valid, in_data, in_last, in_nodata, out_ready,
    output in_ready, out_valid, out_block, out_first, out_last
  );
endinterface

// File: rtl/sha_padder.sv
// SHA-256 message padder: packs a byte stream into 512-bit blocks, appends the
// 0x80 marker, zero fill and 64-bit big-endian bit length.
module sha_padder #(
  parameter int CNT_W = 32
) (
  input  logic        clk,
  input  logic        rst,
  sha_padder_if.slave bus
);
  typedef enum logic [1:0] {FILL, EMIT, TAIL} state_t;

  state_t             state_reg, state_next;
  logic               run_reg;
  logic [5:0]         idx_reg;
  logic [CNT_W-1:0]   len_reg;
  logic               first_reg;
  logic               last_reg;
  logic               tail_pending_reg;
  logic               tail80_reg;
  logic [511:0]       block_reg;
  logic [511:0]       block_next;

  logic               fill_xfer;
  logic               out_xfer;
  logic               out_valid_int;
  logic               has_byte;
  logic [6:0]         pad_pos;
  logic [CNT_W-1:0]   len_inc;
  logic [CNT_W-1:0]   len_final;
  logic [63:0]        bitlen_fill;
  logic [63:0]        bitlen_tail;
  logic [511:0]       fill_len_blk;
  logic [511:0]       tail_blk;

  assign out_valid_int = (state_reg != FILL);
  assign fill_xfer     = bus.in_valid && run_reg && (state_reg == FILL);
  assign out_xfer      = out_valid_int && bus.out_ready;
  assign has_byte      = !(bus.in_last && bus.in_nodata);
  // Position of the 0x80 marker: one past the final message byte (64 = next block).
  assign pad_pos       = has_byte ? ({1'b0, idx_reg} + 7'd1) : {1'b0, idx_reg};
  assign len_inc       = len_reg + CNT_W'(1);
  assign len_final     = has_byte ? len_inc : len_reg;

  always_comb begin
    bitlen_fill = '0;
    bitlen_fill[CNT_W+2:0] = {len_final, 3'b000};
    bitlen_tail = '0;
    bitlen_tail[CNT_W+2:0] = {len_reg, 3'b000};
  end

  assign fill_len_blk = {448'd0, bitlen_fill};
  assign tail_blk     = {(tail80_reg ? 8'h80 : 8'h00), 440'd0, bitlen_tail};

  genvar gi;
  generate
    for (gi = 0; gi < 64; gi++) begin : g_byte
      logic [7:0] byte_next;
      always_comb begin
        byte_next = block_reg[511-8*gi -: 8];
        if (fill_xfer) begin
          if (has_byte && idx_reg == 6'(gi))
            byte_next = bus.in_data;
          else if (bus.in_last && pad_pos == 7'(gi))
            byte_next = 8'h80;
          else if (bus.in_last && pad_pos < 7'(gi))
            byte_next = (pad_pos <= 7'd55) ? fill_len_blk[511-8*gi -: 8] : 8'h00;
        end else if (out_xfer) begin
          byte_next = (!last_reg && tail_pending_reg) ? tail_blk[511-8*gi -: 8] : 8'h00;
        end
      end
      assign block_next[511-8*gi -: 8] = byte_next;
    end
  endgenerate

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_reg <= FILL;
    else      state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      FILL:    if (fill_xfer && (bus.in_last || idx_reg == 6'd63)) state_next = EMIT;
      EMIT:    if (out_xfer) state_next = (!last_reg && tail_pending_reg) ? TAIL : FILL;
      TAIL:    if (out_xfer) state_next = FILL;
      default: state_next = FILL;
    endcase
  end

  always_comb begin
    bus.in_ready  = run_reg && (state_reg == FILL);
    bus.out_valid = out_valid_int;
    bus.out_block = out_valid_int ? block_reg : '0;
    bus.out_first = out_valid_int && first_reg;
    bus.out_last  = out_valid_int && last_reg;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      run_reg          <= 1'b0;
      idx_reg          <= '0;
      len_reg          <= '0;
      first_reg        <= 1'b1;
      last_reg         <= 1'b0;
      tail_pending_reg <= 1'b0;
      tail80_reg       <= 1'b0;
      block_reg        <= '0;
    end else begin
      run_reg   <= 1'b1;
      block_reg <= block_next;
      if (fill_xfer) begin
        if (has_byte) len_reg <= len_inc;
        if (bus.in_last) begin
          last_reg         <= (pad_pos <= 7'd55);
          tail_pending_reg <= (pad_pos > 7'd55);
          tail80_reg       <= (pad_pos == 7'd64);
        end else begin
          idx_reg          <= idx_reg + 6'd1;
          last_reg         <= 1'b0;
          tail_pending_reg <= 1'b0;
        end
      end else if (out_xfer) begin
        idx_reg          <= '0;
        first_reg        <= last_reg;
        if (last_reg) len_reg <= '0;
        // A pending tail block becomes the final block of the message.
        last_reg         <= tail_pending_reg && !last_reg;
        tail_pending_reg <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_sha_padder.sv
// Directed bench for sha_padder: known-answer padding vectors, back-pressure,
// back-to-back messages and reset mid-message / mid-emit.
module tb_sha_padder;
  typedef logic [7:0] byte_q_t[$];
  typedef struct {
    logic [511:0] blk;
    logic         first;
    logic         last;
  } obs_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;
  obs_t obs_q[$];

  sha_padder_if bus ();

  sha_padder #(.CNT_W(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rst && bus.out_valid && bus.out_ready) begin
      obs_t o;
      o.blk   = bus.out_block;
      o.first = bus.out_first;
      o.last  = bus.out_last;
      obs_q.push_back(o);
      $display("block out: first=%0d last=%0d data=%0h", o.first, o.last, o.blk);
    end
  end

  task automatic check_val(input string tag, input logic [511:0] got, input logic [511:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic byte_q_t gen_msg(input int n, input int seed);
    byte_q_t m;
    for (int i = 0; i < n; i++) m.push_back(8'(i * 7 + seed));
    return m;
  endfunction

  // Reference SHA-256 padding: msg, 0x80, zeros to 56 mod 64, 64-bit bit length.
  function automatic byte_q_t pad_msg(input byte_q_t msg);
    byte_q_t     p;
    logic [63:0] bl;
    bl = 64'(msg.size()) * 64'd8;
    p  = msg;
    p.push_back(8'h80);
    while (p.size() % 64 != 56) p.push_back(8'h00);
    for (int i = 7; i >= 0; i--) p.push_back(bl[8*i +: 8]);
    return p;
  endfunction

  function automatic logic [511:0] blk_of(input byte_q_t p, input int b);
    logic [511:0] e;
    for (int k = 0; k < 64; k++) e[511-8*k -: 8] = p[64*b + k];
    return e;
  endfunction

  task automatic send_beat(input logic [7:0] d, input logic last, input logic nodata);
    int n;
    bus.in_valid  = 1'b1;
    bus.in_data   = d;
    bus.in_last   = last;
    bus.in_nodata = nodata;
    n = 0;
    while (!bus.in_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (!bus.in_ready) begin
      check_val("beat_accept", bus.in_ready, 1);
    end else begin
      @(posedge clk);
      #1;
    end
    bus.in_valid  = 1'b0;
    bus.in_last   = 1'b0;
    bus.in_nodata = 1'b0;
  endtask

  task automatic send_msg(input byte_q_t m);
    for (int i = 0; i < m.size(); i++) send_beat(m[i], (i == m.size() - 1), 1'b0);
  endtask

  task automatic wait_blocks(input int n);
    int c;
    c = 0;
    while (obs_q.size() < n && c < 500) begin
      @(negedge clk);
      c++;
    end
    check_val("block_count", (obs_q.size() >= n), 1);
  endtask

  task automatic pop_cmp(input string tag, input logic [511:0] exp, input logic first, input logic last);
    obs_t o;
    if (obs_q.size() == 0) begin
      check_val({tag, "_present"}, 0, 1);
    end else begin
      o = obs_q.pop_front();
      check_val({tag, "_blk"}, o.blk, exp);
      check_val({tag, "_first"}, o.first, first);
      check_val({tag, "_last"}, o.last, last);
    end
  endtask

  task automatic expect_msg(input string tag, input byte_q_t m);
    byte_q_t p;
    int      nb;
    p  = pad_msg(m);
    nb = p.size() / 64;
    wait_blocks(nb);
    for (int b = 0; b < nb; b++)
      pop_cmp($sformatf("%s_b%0d", tag, b), blk_of(p, b), (b == 0), (b == nb - 1));
  endtask

  localparam logic [511:0] ABC_BLK = {32'h61626380, 416'd0, 64'h18};
  localparam logic [511:0] EMPTY_BLK = {8'h80, 504'd0};

  initial begin
    byte_q_t abc, m, p;
    abc = '{8'h61, 8'h62, 8'h63};
    bus.in_valid  = 1'b0;
    bus.in_data   = 8'h00;
    bus.in_last   = 1'b0;
    bus.in_nodata = 1'b0;
    bus.out_ready = 1'b1;

    repeat (3) @(negedge clk);
    check_val("rst_in_ready", bus.in_ready, 0);
    check_val("rst_out_valid", bus.out_valid, 0);
    check_val("rst_out_block", bus.out_block, 0);
    check_val("rst_out_first", bus.out_first, 0);
    check_val("rst_out_last", bus.out_last, 0);
    rst = 1'b1;
    @(negedge clk);
    check_val("rdy_after_rst", bus.in_ready, 1);

    // "abc", plus one-cycle latency from the last beat
    send_msg(abc);
    check_val("abc_latency", bus.out_valid, 1);
    wait_blocks(1);
    pop_cmp("abc", ABC_BLK, 1, 1);

    // Length boundaries around the 56-byte and 64-byte points
    m = gen_msg(55, 3);  send_msg(m); expect_msg("len55", m);
    m = gen_msg(56, 11); send_msg(m); expect_msg("len56", m);
    m = gen_msg(64, 5);  send_msg(m); expect_msg("len64", m);
    m = gen_msg(65, 9);  send_msg(m); expect_msg("len65", m);

    // Empty message: one nodata last beat
    send_beat(8'hAA, 1'b1, 1'b1);
    wait_blocks(1);
    pop_cmp("empty", EMPTY_BLK, 1, 1);

    // Back-pressure on the data block and on the tail block
    bus.out_ready = 1'b0;
    m = gen_msg(56, 21);
    p = pad_msg(m);
    send_msg(m);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check_val("stall1_blk", bus.out_block, blk_of(p, 0));
      check_val("stall1_valid", bus.out_valid, 1);
      check_val("stall1_rdy", bus.in_ready, 0);
      check_val("stall1_fl", {bus.out_first, bus.out_last}, 2'b10);
    end
    check_val("stall1_none", obs_q.size(), 0);
    @(posedge clk); #1; bus.out_ready = 1'b1;
    @(posedge clk); #1; bus.out_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check_val("stall2_blk", bus.out_block, blk_of(p, 1));
      check_val("stall2_rdy", bus.in_ready, 0);
      check_val("stall2_fl", {bus.out_first, bus.out_last}, 2'b01);
    end
    check_val("stall2_one", obs_q.size(), 1);
    @(posedge clk); #1; bus.out_ready = 1'b1;
    expect_msg("stall", m);

    // Back-to-back messages: out_first restarts on each message
    m = gen_msg(64, 40);
    send_msg(m);
    send_msg(abc);
    expect_msg("b2b_64", m);
    wait_blocks(1);
    pop_cmp("b2b_abc", ABC_BLK, 1, 1);

    // Reset after 20 bytes discards the partial message
    m = gen_msg(20, 1);
    for (int i = 0; i < 20; i++) send_beat(m[i], 1'b0, 1'b0);
    rst = 1'b0;
    #2;
    check_val("midrst_in_ready", bus.in_ready, 0);
    check_val("midrst_out_valid", bus.out_valid, 0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_val("midrst_rdy", bus.in_ready, 1);
    send_msg(abc);
    wait_blocks(1);
    check_val("midrst_count", obs_q.size(), 1);
    pop_cmp("midrst_abc", ABC_BLK, 1, 1);

    // Reset while a block is waiting in EMIT
    bus.out_ready = 1'b0;
    send_msg(abc);
    repeat (2) @(negedge clk);
    check_val("emitrst_pre", bus.out_valid, 1);
    rst = 1'b0;
    #2;
    check_val("emitrst_valid", bus.out_valid, 0);
    check_val("emitrst_block", bus.out_block, 0);
    bus.out_ready = 1'b1;
    @(negedge clk);
    rst = 1'b1;
    repeat (5) @(negedge clk);
    check_val("emitrst_none", obs_q.size(), 0);
    send_msg(abc);
    wait_blocks(1);
    pop_cmp("emitrst_abc", ABC_BLK, 1, 1);

    repeat (3) @(negedge clk);
    check_val("final_extra", obs_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule

// File: doc/sha_padder.md
SHA_PADDER -- requirements
Module: sha_padder

Interface
REQ-001 Parameter: CNT_W, default 32, width of the message byte counter (2..61).
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  asynchronous, active-low reset.
REQ-004 in_valid  input  1  input beat valid.
REQ-005 in_ready  output  1  block accepts a beat this cycle.
REQ-006 in_data  input  8  message byte; first byte of the message goes to the block MSBs.
REQ-007 in_last  input  1  beat is the final beat of the message.
REQ-008 in_nodata  input  1  beat carries no byte; legal only with in_last=1; ignored otherwise.
REQ-009 out_valid  output  1  out_block holds a padded 512-bit block.
REQ-010 out_ready  input  1  downstream (SHA-256 compression core) consumes the block.
REQ-011 out_block  output  512  padded block, byte k at bits [511-8k -: 8].
REQ-012 out_first  output  1  block is the first block of its message.
REQ-013 out_last  output  1  block is the final block of its message.

Function
REQ-014 A beat SHALL transfer when in_valid and in_ready are both 1 on a rising edge; an output block SHALL transfer when out_valid and out_ready are both 1.
REQ-015 States SHALL be FILL, EMIT and TAIL; in_ready = 1 only in FILL; out_valid = 1 only in EMIT and TAIL.
REQ-016 In FILL, a data byte SHALL be written at the byte index idx (0..63); idx then increments, and the byte counter len increments modulo 2^CNT_W.
REQ-017 A non-last byte at idx 63 SHALL move the FSM to EMIT with out_last=0 on the next cycle; idx resets to 0 after the EMIT transfer, then FILL.
REQ-018 On a last beat, let p be the index of the final message byte (p = idx for a data beat, idx-1 for a nodata beat; p = -1 for an empty block).
REQ-019 The registered block SHALL hold 0x80 at byte p+1 if p+1 <= 63, with zeros at all later bytes.
REQ-020 If p <= 54, bytes 56..63 SHALL hold the 64-bit big-endian bit length ({len,3'b000} zero-extended), and EMIT SHALL present the block with out_last=1.
REQ-021 If 55 <= p <= 63, EMIT SHALL present the block with out_last=0; after that transfer, the FSM SHALL enter TAIL.
REQ-022 The TAIL block SHALL hold byte 0 = 0x80 if p = 63 (else 0x00), zeros through byte 55, bit length in bytes 56..63, and out_last=1.
REQ-023 After the out_last=1 transfer, the FSM SHALL return to FILL with idx=0, len=0, and the first-flag set.
REQ-024 out_first SHALL be 1 on the first block emitted after a message start and 0 on all others (including TAIL unless it is the only block, which is impossible).
REQ-025 out_block, out_first and out_last SHALL stay stable while out_valid=1 and out_ready=0.
REQ-026 Latency: out_valid SHALL rise exactly one cycle after the beat that completes or ends a block; minimum throughput is 65 cycles per full block.
REQ-027 Messages longer than 2^CNT_W-1 bytes are unsupported; the counter wraps with no error indication.
REQ-028 in_data SHALL be ignored on nodata beats; in_last/in_nodata SHALL be ignored when in_valid=0.

Reset
REQ-029 While rst=0, the block SHALL be in FILL with idx=0, len=0 and the first-flag set, with out_valid=0, out_block=0, out_first=0, out_last=0 and in_ready=0.
REQ-030 in_ready SHALL rise the first cycle after rst deasserts; assertion mid-message or mid-EMIT SHALL discard all partial state without emitting a block.

Verification
REQ-031 "abc" (3 data beats, last on 'c') -> one block 0x61626380, zeros, and length 0x...0018; out_first=1, out_last=1.
REQ-032 55-byte message -> one block with 0x80 at byte 55 and length 0x1B8; 56-byte message -> block 1 with 0x80 at byte 56 and out_last=0, then TAIL block of zeros with length 0x1C0.
REQ-033 64-byte message -> data block (out_last=0), then TAIL block with byte0 = 0x80 and length 0x200; 65-byte message -> a second block with 0x80 at byte 1 and length 0x208.
REQ-034 Empty message (single nodata last beat) -> one block with byte0 = 0x80, rest zero, and length 0; out_first=1, out_last=1.
REQ-035 out_ready held low for 5 cycles during EMIT and TAIL -> outputs held stable with in_ready=0; single transfer on release; back-to-back messages have correct out_first.
REQ-036 rst pulsed low after 20 bytes of a message -> no block emitted; a subsequent "abc" yields the REQ-031 block exactly.
